// File: rtl/imm_encoder_unit.sv
// Immediate encoder: validates a 32-bit immediate for an I/S/B/J/U slot, scatters it
// into instr[31:7], merges with base bits and opcode, and buffers results in a 2-entry FIFO.
module imm_encoder_unit #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_imm_src,
  input  logic [31:0]          i_imm,
  input  logic [24:0]          i_base,
  input  logic [6:0]           i_opcode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  logic [24:0] imm_mask;
  logic [24:0] imm_bits;
  logic        enc_err;
  logic [24:0] field;
  logic [31:0] enc_instr;

  logic        sext_ok_11;
  logic        sext_ok_12;
  logic        sext_ok_20;
  logic        sext_ok_19;

  logic [31:0]          entry_instr_q [0:1];
  logic [31:0]          entry_instr_d [0:1];
  logic                 entry_err_q   [0:1];
  logic                 entry_err_d   [0:1];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic push;
  logic pop;

  // An immediate fits when every bit above the field's sign bit repeats that sign bit.
  assign sext_ok_11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign sext_ok_12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign sext_ok_20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
  assign sext_ok_19 = (&i_imm[31:19]) | ~(|i_imm[31:19]);

  always_comb begin
    imm_mask = '0;
    imm_bits = '0;
    enc_err  = 1'b1;
    case (i_imm_src)
      IMM_I: begin
        imm_mask = 25'h1FFE000;
        imm_bits = {i_imm[11:0], 13'b0};
        enc_err  = ~sext_ok_11;
      end
      IMM_S: begin
        imm_mask = 25'h1FC001F;
        imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0]};
        enc_err  = ~sext_ok_11;
      end
      IMM_B: begin
        imm_mask = 25'h1FC001F;
        imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11]};
        enc_err  = ~sext_ok_12 | i_imm[0];
      end
      IMM_J: begin
        imm_mask = 25'h1FFFFE0;
        imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 5'b0};
        enc_err  = ~sext_ok_20 | i_imm[0];
      end
      IMM_U: begin
        imm_mask = 25'h1FFFFE0;
        imm_bits = {i_imm[19:0], 5'b0};
        enc_err  = ~sext_ok_19;
      end
      default: begin
        imm_mask = '0;
        imm_bits = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign field     = (i_base & ~imm_mask) | (enc_err ? 25'b0 : imm_bits);
  assign enc_instr = {field, i_opcode};

  assign o_ready = (count_q != 2'd2);
  assign o_valid = (count_q != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  assign o_instr   = o_valid ? entry_instr_q[rd_ptr_q] : 32'b0;
  assign o_err     = o_valid ? entry_err_q[rd_ptr_q]   : 1'b0;
  assign o_err_cnt = err_cnt_q;

  always_comb begin
    entry_instr_d = entry_instr_q;
    entry_err_d   = entry_err_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    err_cnt_d     = err_cnt_q;

    if (push) begin
      entry_instr_d[wr_ptr_q] = enc_instr;
      entry_err_d[wr_ptr_q]   = enc_err;
      wr_ptr_d                = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (push && enc_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      entry_instr_q[0] <= '0;
      entry_instr_q[1] <= '0;
      entry_err_q[0]   <= 1'b0;
      entry_err_q[1]   <= 1'b0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
      err_cnt_q        <= '0;
    end else begin
      entry_instr_q <= entry_instr_d;
      entry_err_q   <= entry_err_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder_unit.sv
// Directed bench for imm_encoder_unit: encodings, error flags, backpressure,
// mid-operation reset and error-counter saturation.
module tb_imm_encoder_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_imm_src;
  logic [31:0] i_imm;
  logic [24:0] i_base;
  logic [6:0]  i_opcode;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  int checks;
  int passes;

  imm_encoder_unit #(.ERR_CNT_W(8)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_imm_src (i_imm_src),
    .i_imm     (i_imm),
    .i_base    (i_base),
    .i_opcode  (i_opcode),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_instr   (o_instr),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    assert (actual === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] src, input logic [31:0] imm,
                               input logic [24:0] base, input logic [6:0] opc);
    i_imm_src = src;
    i_imm     = imm;
    i_base    = base;
    i_opcode  = opc;
    i_valid   = 1'b1;
  endtask

  // One request through an idle buffer: accepted at the next edge, visible one cycle later, popped after.
  task automatic runSingle(input string tag, input logic [2:0] src, input logic [31:0] imm,
                           input logic [24:0] base, input logic [6:0] opc,
                           input logic [31:0] exp_instr, input logic exp_err);
    applyStimulus(src, imm, base, opc);
    checkOutput({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checkOutput({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    checkOutput({tag, "_instr"}, o_instr, exp_instr);
    checkOutput({tag, "_err"}, {31'b0, o_err}, {31'b0, exp_err});
    @(posedge i_clk); #1;
    checkOutput({tag, "_drained"}, {31'b0, o_valid}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_imm_src = 3'b000;
    i_imm     = 32'h0;
    i_base    = 25'h0;
    i_opcode  = 7'h0;

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("rst_instr", o_instr, 32'h0);
    checkOutput("rst_err", {31'b0, o_err}, 32'd0);
    checkOutput("rst_errcnt", {24'b0, o_err_cnt}, 32'd0);
    i_rst_n = 1'b1;

    runSingle("i_neg1", 3'b000, 32'hFFFF_FFFF, 25'h0, 7'h13, 32'hFFF0_0013, 1'b0);
    runSingle("s_7ff", 3'b001, 32'h0000_07FF, 25'h0, 7'h23, 32'h7E00_0FA3, 1'b0);
    runSingle("j_800", 3'b011, 32'h0000_0800, 25'h0, 7'h6F, 32'h0010_006F, 1'b0);
    runSingle("b_odd", 3'b010, 32'h0000_0001, 25'h0, 7'h63, 32'h0000_0063, 1'b1);
    checkOutput("b_odd_errcnt", {24'b0, o_err_cnt}, 32'd1);
    runSingle("u_ovf", 3'b100, 32'h0008_0000, 25'h0, 7'h37, 32'h0000_0037, 1'b1);
    runSingle("u_neg", 3'b100, 32'hFFFF_F000, 25'h0, 7'h37, 32'hFF00_0037, 1'b0);
    runSingle("t111", 3'b111, 32'h0000_0004, 25'h1234567, 7'h13, 32'h91A2_B393, 1'b1);
    runSingle("i_base", 3'b000, 32'h0000_0005, 25'h1FFFFFF, 7'h13, 32'h005F_FF93, 1'b0);
    runSingle("s_ovf", 3'b001, 32'h0000_0800, 25'h1FFFFFF, 7'h23, 32'h01FF_F023, 1'b1);
    checkOutput("errcnt4", {24'b0, o_err_cnt}, 32'd4);

    // Backpressure: two entries fill the buffer, the third request is held until a slot frees.
    i_ready = 1'b0;
    applyStimulus(3'b000, 32'h1, 25'h0, 7'h13);
    @(posedge i_clk); #1;
    applyStimulus(3'b000, 32'h2, 25'h0, 7'h13);
    @(posedge i_clk); #1;
    applyStimulus(3'b000, 32'h3, 25'h0, 7'h13);
    checkOutput("bp_full_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("bp_head0", o_instr, 32'h0010_0013);
    @(posedge i_clk); #1;
    checkOutput("bp_hold_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("bp_hold_valid", {31'b0, o_valid}, 32'd1);
    checkOutput("bp_hold_head", o_instr, 32'h0010_0013);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("bp_head1", o_instr, 32'h0020_0013);
    checkOutput("bp_slot_ready", {31'b0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checkOutput("bp_head2", o_instr, 32'h0030_0013);
    checkOutput("bp_head2_valid", {31'b0, o_valid}, 32'd1);
    @(posedge i_clk); #1;
    checkOutput("bp_empty", {31'b0, o_valid}, 32'd0);
    checkOutput("bp_empty_instr", o_instr, 32'h0);

    // Fill with one erroneous and one clean entry, then reset while full.
    i_ready = 1'b0;
    applyStimulus(3'b010, 32'h1, 25'h0, 7'h63);
    @(posedge i_clk); #1;
    applyStimulus(3'b000, 32'h4, 25'h0, 7'h13);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checkOutput("pre_rst_errcnt", {24'b0, o_err_cnt}, 32'd5);
    checkOutput("pre_rst_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("pre_rst_err", {31'b0, o_err}, 32'd1);
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    applyStimulus(3'b111, 32'h0, 25'h0, 7'h13);
    @(posedge i_clk); #1;
    checkOutput("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("mid_rst_errcnt", {24'b0, o_err_cnt}, 32'd0);
    checkOutput("mid_rst_instr", o_instr, 32'h0);
    @(posedge i_clk); #1;
    checkOutput("rst_push_ignored", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_push_errcnt", {24'b0, o_err_cnt}, 32'd0);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;

    // Stream erroneous requests at full rate to saturate the counter.
    applyStimulus(3'b101, 32'h0, 25'h0ABCDEF, 7'h33);
    repeat (255) @(posedge i_clk);
    #1;
    checkOutput("sat_255", {24'b0, o_err_cnt}, 32'd255);
    checkOutput("sat_err", {31'b0, o_err}, 32'd1);
    checkOutput("sat_instr", o_instr, 32'h55E6_F7B3);
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("sat_hold", {24'b0, o_err_cnt}, 32'd255);
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("final_empty", {31'b0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
